// File: rtl/uld_pkg.sv
// Shared types and constants for the uLD descriptor issuer.
// Holds the unpacked descriptor struct, FSM states and word/bit layout.
package uld_pkg;

    // Descriptor word indices within one table entry.
    localparam int W_ID       = 0;
    localparam int W_DIMS     = 1;
    localparam int W_QUANT    = 2;
    localparam int W_IFMAP    = 3;
    localparam int W_WEIGHT   = 4;
    localparam int W_BIAS     = 5;
    localparam int W_OFMAP    = 6;
    localparam int DESC_WORDS = 7;

    // W0 bit positions.
    localparam int W0_ID_LSB     = 0;
    localparam int W0_TYPE_LSB   = 6;
    localparam int W0_INR_LSB    = 8;
    localparam int W0_INC_LSB    = 15;
    localparam int W0_STRIDE_LSB = 22;
    localparam int W0_PADT_LSB   = 24;
    localparam int W0_PADB_LSB   = 26;
    localparam int W0_PADL_LSB   = 28;
    localparam int W0_PADR_LSB   = 30;

    // W1 bit positions.
    localparam int W1_IND_LSB   = 0;
    localparam int W1_OUTK_LSB  = 11;
    localparam int W1_FLAGS_LSB = 22;

    // W2 bit positions.
    localparam int W2_QS_LSB = 0;

    typedef struct packed {
        logic [5:0]  layer_id;
        logic [1:0]  layer_type;
        logic [6:0]  in_R;
        logic [6:0]  in_C;
        logic [10:0] in_D;
        logic [10:0] out_K;
        logic [1:0]  stride;
        logic [1:0]  pad_T;
        logic [1:0]  pad_B;
        logic [1:0]  pad_L;
        logic [1:0]  pad_R;
        logic [31:0] base_ifmap;
        logic [31:0] base_weight;
        logic [31:0] base_bias;
        logic [31:0] base_ofmap;
        logic [3:0]  flags;
        logic [7:0]  quant_scale;
    } uld_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_ISSUE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/uld_field_unpack.sv
// Combinational unpack of seven raw descriptor words into uld_t.
// Ports: words (7x32 raw descriptor words), uld (unpacked fields).
module uld_field_unpack
    import uld_pkg::*;
(
    input  logic [DESC_WORDS-1:0][31:0] words,
    output uld_t                        uld
);

    // Reserved descriptor bits are deliberately dropped.
    logic unused_rsvd;
    assign unused_rsvd = ^{words[W_DIMS][31:26], words[W_QUANT][31:8]};

    always_comb begin
        uld             = '0;
        uld.layer_id    = words[W_ID][W0_ID_LSB +: 6];
        uld.layer_type  = words[W_ID][W0_TYPE_LSB +: 2];
        uld.in_R        = words[W_ID][W0_INR_LSB +: 7];
        uld.in_C        = words[W_ID][W0_INC_LSB +: 7];
        uld.stride      = words[W_ID][W0_STRIDE_LSB +: 2];
        uld.pad_T       = words[W_ID][W0_PADT_LSB +: 2];
        uld.pad_B       = words[W_ID][W0_PADB_LSB +: 2];
        uld.pad_L       = words[W_ID][W0_PADL_LSB +: 2];
        uld.pad_R       = words[W_ID][W0_PADR_LSB +: 2];
        uld.in_D        = words[W_DIMS][W1_IND_LSB +: 11];
        uld.out_K       = words[W_DIMS][W1_OUTK_LSB +: 11];
        uld.flags       = words[W_DIMS][W1_FLAGS_LSB +: 4];
        uld.quant_scale = words[W_QUANT][W2_QS_LSB +: 8];
        uld.base_ifmap  = words[W_IFMAP];
        uld.base_weight = words[W_WEIGHT];
        uld.base_bias   = words[W_BIAS];
        uld.base_ofmap  = words[W_OFMAP];
    end

endmodule

// File: rtl/uld_issuer.sv
// Fetches per-layer descriptors, validates and issues them to the decoder.
// Ports: clk/rst, start_i/desc_base_i/num_layers_i (job), mem_* (read port),
//        uLD_en_o + field outputs (decoder), layer_start_o/layer_done_i,
//        busy_o/done_o/err_o (status).
module uld_issuer
    import uld_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DESC_STRIDE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] desc_base_i,
    input  logic [6:0]        num_layers_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              uLD_en_o,
    output logic [5:0]        layer_id_o,
    output logic [1:0]        layer_type_o,
    output logic [6:0]        in_R_o,
    output logic [6:0]        in_C_o,
    output logic [10:0]       in_D_o,
    output logic [10:0]       out_K_o,
    output logic [1:0]        stride_o,
    output logic [1:0]        pad_T_o,
    output logic [1:0]        pad_B_o,
    output logic [1:0]        pad_L_o,
    output logic [1:0]        pad_R_o,
    output logic [31:0]       base_ifmap_o,
    output logic [31:0]       base_weight_o,
    output logic [31:0]       base_bias_o,
    output logic [31:0]       base_ofmap_o,
    output logic [3:0]        flags_o,
    output logic [7:0]        quant_scale_o,
    output logic              layer_start_o,
    input  logic              layer_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(DESC_STRIDE);

    state_e                      state_q;
    state_e                      state_d;
    logic [ADDR_W-1:0]           base_q;
    logic [6:0]                  count_q;
    logic [6:0]                  layer_idx_q;
    logic [6:0]                  layer_idx_inc;
    logic [2:0]                  word_idx_q;
    logic [DESC_WORDS-1:0][31:0] shadow_q;
    uld_t                        shadow_uld;
    uld_t                        out_q;
    logic                        err_q;
    logic                        run_first_q;
    logic                        bad;
    logic                        last_word;
    logic [ADDR_W-1:0]           addr;

    uld_field_unpack u_unpack (
        .words (shadow_q),
        .uld   (shadow_uld)
    );

    assign layer_idx_inc = layer_idx_q + 7'd1;
    assign last_word     = (word_idx_q == 3'(W_OFMAP));

    // Descriptors the decoder cannot tile are rejected before issue.
    assign bad = (shadow_uld.stride == 2'd0)
              || (shadow_uld.in_R == 7'd0)
              || (shadow_uld.in_C == 7'd0);

    // Wraps modulo 2^ADDR_W by construction.
    assign addr = base_q
                + (ADDR_W'(layer_idx_q) * STRIDE_A)
                + ADDR_W'({word_idx_q, 2'b00});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (num_layers_i == 7'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = last_word ? S_CHECK : S_REQ;
                end
            end
            S_CHECK: state_d = bad ? S_IDLE : S_ISSUE;
            S_ISSUE: state_d = S_RUN;
            S_RUN: begin
                if (layer_done_i) begin
                    state_d = (layer_idx_inc == count_q) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        uLD_en_o      = 1'b0;
        layer_start_o = 1'b0;
        done_o        = 1'b0;
        busy_o        = 1'b1;
        unique case (state_q)
            S_IDLE: busy_o = 1'b0;
            S_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr;
            end
            S_ISSUE: uLD_en_o = 1'b1;
            S_RUN:   layer_start_o = run_first_q;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Job registers, shadow capture and the issued field bank.
    // The field bank loads on the edge into ISSUE so it is valid
    // in the same cycle as uLD_en_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            count_q     <= '0;
            layer_idx_q <= '0;
            word_idx_q  <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
            run_first_q <= 1'b0;
        end else begin
            run_first_q <= (state_q == S_ISSUE);
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base_q      <= desc_base_i;
                        count_q     <= num_layers_i;
                        err_q       <= 1'b0;
                        layer_idx_q <= '0;
                        word_idx_q  <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        shadow_q[word_idx_q] <= mem_rdata_i;
                        if (!last_word) begin
                            word_idx_q <= word_idx_q + 3'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (bad) begin
                        err_q <= 1'b1;
                    end else begin
                        out_q <= shadow_uld;
                    end
                end
                S_RUN: begin
                    if (layer_done_i) begin
                        layer_idx_q <= layer_idx_inc;
                        word_idx_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_o         = err_q;
    assign layer_id_o    = out_q.layer_id;
    assign layer_type_o  = out_q.layer_type;
    assign in_R_o        = out_q.in_R;
    assign in_C_o        = out_q.in_C;
    assign in_D_o        = out_q.in_D;
    assign out_K_o       = out_q.out_K;
    assign stride_o      = out_q.stride;
    assign pad_T_o       = out_q.pad_T;
    assign pad_B_o       = out_q.pad_B;
    assign pad_L_o       = out_q.pad_L;
    assign pad_R_o       = out_q.pad_R;
    assign base_ifmap_o  = out_q.base_ifmap;
    assign base_weight_o = out_q.base_weight;
    assign base_bias_o   = out_q.base_bias;
    assign base_ofmap_o  = out_q.base_ofmap;
    assign flags_o       = out_q.flags;
    assign quant_scale_o = out_q.quant_scale;

endmodule

// File: tb/tb_uld_issuer.sv
// Directed bench for uld_issuer with a memory responder and scoreboards.
// Expected addresses and issued fields are queued as stimulus is set up.
module tb_uld_issuer;
    import uld_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] desc_base_i = '0;
    logic [6:0]  num_layers_i = '0;
    logic        layer_done_i = 1'b0;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        uLD_en_o;
    logic [5:0]  layer_id_o;
    logic [1:0]  layer_type_o;
    logic [6:0]  in_R_o;
    logic [6:0]  in_C_o;
    logic [10:0] in_D_o;
    logic [10:0] out_K_o;
    logic [1:0]  stride_o;
    logic [1:0]  pad_T_o;
    logic [1:0]  pad_B_o;
    logic [1:0]  pad_L_o;
    logic [1:0]  pad_R_o;
    logic [31:0] base_ifmap_o;
    logic [31:0] base_weight_o;
    logic [31:0] base_bias_o;
    logic [31:0] base_ofmap_o;
    logic [3:0]  flags_o;
    logic [7:0]  quant_scale_o;
    logic        layer_start_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    uld_issuer #(.ADDR_W(32), .DESC_STRIDE(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .desc_base_i   (desc_base_i),
        .num_layers_i  (num_layers_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .uLD_en_o      (uLD_en_o),
        .layer_id_o    (layer_id_o),
        .layer_type_o  (layer_type_o),
        .in_R_o        (in_R_o),
        .in_C_o        (in_C_o),
        .in_D_o        (in_D_o),
        .out_K_o       (out_K_o),
        .stride_o      (stride_o),
        .pad_T_o       (pad_T_o),
        .pad_B_o       (pad_B_o),
        .pad_L_o       (pad_L_o),
        .pad_R_o       (pad_R_o),
        .base_ifmap_o  (base_ifmap_o),
        .base_weight_o (base_weight_o),
        .base_bias_o   (base_bias_o),
        .base_ofmap_o  (base_ofmap_o),
        .flags_o       (flags_o),
        .quant_scale_o (quant_scale_o),
        .layer_start_o (layer_start_o),
        .layer_done_i  (layer_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_addr_q [$];
    uld_t        exp_uld_q [$];

    int          gnt_delay = 0;
    int          rv_delay = 0;
    bit          inj_rv = 1'b0;
    int          gcnt = 0;
    int          rcnt = 0;
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;

    uld_t dut_uld;
    uld_t last_uld = '0;
    logic rst_d = 1'b1;

    always_comb begin
        dut_uld             = '0;
        dut_uld.layer_id    = layer_id_o;
        dut_uld.layer_type  = layer_type_o;
        dut_uld.in_R        = in_R_o;
        dut_uld.in_C        = in_C_o;
        dut_uld.in_D        = in_D_o;
        dut_uld.out_K       = out_K_o;
        dut_uld.stride      = stride_o;
        dut_uld.pad_T       = pad_T_o;
        dut_uld.pad_B       = pad_B_o;
        dut_uld.pad_L       = pad_L_o;
        dut_uld.pad_R       = pad_R_o;
        dut_uld.base_ifmap  = base_ifmap_o;
        dut_uld.base_weight = base_weight_o;
        dut_uld.base_bias   = base_bias_o;
        dut_uld.base_ofmap  = base_ofmap_o;
        dut_uld.flags       = flags_o;
        dut_uld.quant_scale = quant_scale_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] waddr(input logic [31:0] base,
                                          input int idx, input int w);
        return base + 32'(idx) * 32'd32 + 32'(w) * 32'd4;
    endfunction

    // Pack fields into descriptor words, with junk in reserved bits.
    function automatic void load_layer(input logic [31:0] base,
                                       input int idx, input uld_t u);
        logic [31:0] w [7];
        w[0] = {u.pad_R, u.pad_L, u.pad_B, u.pad_T, u.stride,
                u.in_C, u.in_R, u.layer_type, u.layer_id};
        w[1] = {6'h2A, u.flags, u.out_K, u.in_D};
        w[2] = {24'hABCDEF, u.quant_scale};
        w[3] = u.base_ifmap;
        w[4] = u.base_weight;
        w[5] = u.base_bias;
        w[6] = u.base_ofmap;
        for (int i = 0; i < 7; i++) begin
            mem[waddr(base, idx, i)] = w[i];
            exp_addr_q.push_back(waddr(base, idx, i));
        end
        exp_uld_q.push_back(u);
    endfunction

    function automatic uld_t mk_uld(input int s);
        uld_t u;
        u.layer_id    = 6'(s + 3);
        u.layer_type  = 2'(s);
        u.in_R        = 7'(s * 5 % 120 + 1);
        u.in_C        = 7'(s * 7 % 120 + 2);
        u.in_D        = 11'(s * 37 + 3);
        u.out_K       = 11'(s * 53 + 5);
        u.stride      = 2'(s % 3 + 1);
        u.pad_T       = 2'(s);
        u.pad_B       = 2'(s + 1);
        u.pad_L       = 2'(s + 2);
        u.pad_R       = 2'(s + 3);
        u.base_ifmap  = 32'h1000_0000 + 32'(s) * 32'h100;
        u.base_weight = 32'h2000_0000 + 32'(s) * 32'h200;
        u.base_bias   = 32'h3000_0000 + 32'(s) * 32'h300;
        u.base_ofmap  = 32'h4000_0000 + 32'(s) * 32'h400;
        u.flags       = 4'(s * 3);
        u.quant_scale = 8'(s * 29 + 7);
        return u;
    endfunction

    // Memory responder: grant after gnt_delay REQ cycles, data rv_delay later.
    always @(negedge clk) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (pend) begin
            if (rcnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_rd(paddr);
                pend         = 1'b0;
            end else begin
                rcnt--;
            end
        end else if (mem_req_o === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                chk("req_unexpected", mem_req_o, 1'b0);
            end
            if (gcnt < gnt_delay) begin
                gcnt++;
                if (exp_addr_q.size() != 0) begin
                    chk("addr_stable", mem_addr_o, exp_addr_q[0]);
                end
                if (inj_rv) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = 32'hBAD0_BAD0;
                end
            end else begin
                gcnt      = 0;
                mem_gnt_i = 1'b1;
                pend      = 1'b1;
                rcnt      = rv_delay;
                paddr     = mem_addr_o;
                if (exp_addr_q.size() != 0) begin
                    chk("addr", mem_addr_o, exp_addr_q.pop_front());
                end
            end
        end
    end

    // Issued-field scoreboard and hold check between issues.
    always @(negedge clk) begin
        if (uLD_en_o === 1'b1) begin
            vectors++;
            if (exp_uld_q.size() == 0) begin
                miscompares++;
                $error("FAIL uld_unexpected: observed %h expected none",
                       dut_uld);
            end else begin
                uld_t e;
                e = exp_uld_q.pop_front();
                assert (dut_uld === e) else begin
                    miscompares++;
                    $error("FAIL uld_fields: observed %h expected %h",
                           dut_uld, e);
                end
            end
        end else if (!rst && !rst_d) begin
            vectors++;
            assert (dut_uld === last_uld) else begin
                miscompares++;
                $error("FAIL uld_hold: observed %h expected %h",
                       dut_uld, last_uld);
            end
        end
        rst_d    = rst;
        last_uld = dut_uld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (uLD_en_o !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, uLD_en_o, 1'b1);
    endtask

    // From the ISSUE cycle: check start pulse, then finish the layer.
    task automatic do_layer(input bit last, input bit inj_issue);
        wait_en("uld_en_seen");
        if (inj_issue) layer_done_i = 1'b1;
        tick();
        layer_done_i = 1'b0;
        chk("layer_start_hi", layer_start_o, 1'b1);
        chk("uld_en_pulse", uLD_en_o, 1'b0);
        tick();
        chk("layer_start_lo", layer_start_o, 1'b0);
        chk("run_hold", {done_o, busy_o, mem_req_o}, 3'b010);
        tick();
        layer_done_i = 1'b1;
        tick();
        layer_done_i = 1'b0;
        if (last) begin
            chk("done_hi", {done_o, busy_o}, 2'b11);
            tick();
            chk("done_lo_idle", {done_o, busy_o}, 2'b00);
        end else begin
            chk("next_req", mem_req_o, 1'b1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {mem_req_o, mem_addr_o, uLD_en_o, layer_start_o,
                  busy_o, done_o, err_o}, '0);
        vectors++;
        assert (dut_uld === '0) else begin
            miscompares++;
            $error("FAIL %s_fields: observed %h expected 0", tag, dut_uld);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        uld_t u;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Invalid descriptor: stride 0, in_C 0.
        mem[32'h1000] = 32'h0000_0241;
        for (int i = 0; i < 7; i++) exp_addr_q.push_back(32'h1000 + 32'(i * 4));
        desc_base_i  = 32'h1000;
        num_layers_i = 7'd1;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t1_req", mem_req_o, 1'b1);
        chk("t1_addr", mem_addr_o, 32'h1000);
        repeat (14) tick();
        chk("t1_check", {busy_o, err_o}, 2'b10);
        tick();
        chk("t1_err", {err_o, busy_o, uLD_en_o}, 3'b100);
        tick();
        chk("t1_err_sticky", {err_o, busy_o}, 2'b10);

        // Single pointwise layer with exact timing.
        u = '0;
        u.layer_id    = 6'd2;
        u.layer_type  = 2'd2;
        u.in_R        = 7'd56;
        u.in_C        = 7'd56;
        u.in_D        = 11'd32;
        u.out_K       = 11'd64;
        u.stride      = 2'd1;
        u.base_ifmap  = 32'h0001_0000;
        u.base_weight = 32'h0002_0000;
        u.base_bias   = 32'h0003_0000;
        u.base_ofmap  = 32'h0004_0000;
        u.flags       = 4'h5;
        u.quant_scale = 8'h80;
        load_layer(32'h2000, 0, u);
        desc_base_i = 32'h2000;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t2_req", {mem_req_o, busy_o, err_o}, 3'b110);
        chk("t2_addr", mem_addr_o, 32'h2000);
        repeat (14) tick();
        chk("t2_check_no_en", uLD_en_o, 1'b0);
        tick();
        chk("t2_en_t16", uLD_en_o, 1'b1);
        chk("t2_in_r", in_R_o, 7'd56);
        do_layer(1'b1, 1'b0);

        // Three layers across the address wrap, slow grants.
        gnt_delay = 3;
        for (int i = 0; i < 3; i++) load_layer(32'hFFFF_FFE0, i, mk_uld(i + 1));
        chk("t3_wrap_addr", exp_addr_q[7], 32'h0000_0000);
        desc_base_i  = 32'hFFFF_FFE0;
        num_layers_i = 7'd3;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        do_layer(1'b0, 1'b0);
        do_layer(1'b0, 1'b0);
        do_layer(1'b1, 1'b0);
        gnt_delay = 0;

        // Empty network.
        num_layers_i = 7'd0;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t4_done", {done_o, mem_req_o}, 2'b10);
        tick();
        chk("t4_idle", {done_o, busy_o, mem_req_o}, 3'b000);

        // Spurious start/layer_done/rvalid during the fetch.
        gnt_delay = 2;
        load_layer(32'h5000, 0, mk_uld(9));
        desc_base_i  = 32'h5000;
        num_layers_i = 7'd1;
        start_i      = 1'b1;
        tick();
        chk("t5_req", mem_req_o, 1'b1);
        start_i      = 1'b1;
        layer_done_i = 1'b1;
        num_layers_i = 7'd5;
        desc_base_i  = 32'h9000;
        inj_rv       = 1'b1;
        repeat (19) tick();
        start_i      = 1'b0;
        layer_done_i = 1'b0;
        inj_rv       = 1'b0;
        repeat (9) tick();
        chk("t5_no_en_t29", uLD_en_o, 1'b0);
        tick();
        chk("t5_en_t30", uLD_en_o, 1'b1);
        do_layer(1'b1, 1'b1);
        gnt_delay = 0;

        // Reset while waiting on layer 2 data.
        rv_delay = 2;
        load_layer(32'h3000, 0, mk_uld(11));
        load_layer(32'h3000, 1, mk_uld(12));
        desc_base_i  = 32'h3000;
        num_layers_i = 7'd2;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        do_layer(1'b0, 1'b0);
        tick();
        chk("t6_in_wait", {busy_o, mem_req_o}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t6_reset");
        exp_addr_q.delete();
        exp_uld_q.delete();
        tick();
        chk("t6_late_rv", {busy_o, mem_req_o}, 2'b00);
        tick();
        chk("t6_idle", {busy_o, mem_req_o, uLD_en_o}, 3'b000);
        rv_delay = 0;
        repeat (2) tick();

        // Fresh start after reset.
        load_layer(32'h4000, 0, mk_uld(20));
        desc_base_i  = 32'h4000;
        num_layers_i = 7'd1;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (14) tick();
        tick();
        chk("t7_en_t16", uLD_en_o, 1'b1);
        do_layer(1'b1, 1'b0);
        chk("t7_err", err_o, 1'b0);

        repeat (3) tick();
        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("uld_q_empty", 32'(exp_uld_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
